// File: rtl/gt_cache_pkg.sv
// Shared cache-side types and widths used by the victim cache and the writeback buffer.
package gt_cache_pkg;

  localparam int LINE_BITS   = 256;
  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = 5;
  localparam int TAG_BITS    = ADDR_BITS - OFFSET_BITS;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [TAG_BITS-1:0]  tag_t;

  function automatic tag_t addrToTag(input logic [ADDR_BITS-1:0] addr);
    return addr[ADDR_BITS-1:OFFSET_BITS];
  endfunction

endpackage

// File: rtl/gt_writeback_buffer_if.sv
// Eviction, memory-write and read-forward signals between the victim cache, memory and the buffer.
interface gt_writeback_buffer_if #(
  parameter int DEPTH = 4
);
  import gt_cache_pkg::*;

  logic                   evictValid;
  logic [ADDR_BITS-1:0]   evictAddr;
  line_t                  evictData;
  logic                   evictReady;

  logic                   memWrValid;
  logic [ADDR_BITS-1:0]   memWrAddr;
  line_t                  memWrData;
  logic                   memWrReady;

  logic [ADDR_BITS-1:0]   lookupAddr;
  logic                   lookupHit;
  line_t                  lookupData;

  logic [$clog2(DEPTH):0] count;

  modport master (
    output evictValid, evictAddr, evictData, memWrReady, lookupAddr,
    input  evictReady, memWrValid, memWrAddr, memWrData, lookupHit, lookupData, count
  );

  modport slave (
    input  evictValid, evictAddr, evictData, memWrReady, lookupAddr,
    output evictReady, memWrValid, memWrAddr, memWrData, lookupHit, lookupData, count
  );

endinterface

// File: rtl/gt_wb_match.sv
// DEPTH-way tag compare; when several entries match, the one furthest from the head (youngest) wins.
module gt_wb_match
  import gt_cache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  tag_t             tag_i,
  input  tag_t             tags_i [DEPTH],
  input  logic [DEPTH-1:0] valid_i,
  input  logic [PTR_W-1:0] head_i,
  output logic             hit_o,
  output logic [DEPTH-1:0] onehot_o
);

  logic [PTR_W-1:0] age;
  logic [PTR_W-1:0] bestAge;
  logic [PTR_W-1:0] bestIdx;

  // Age is the slot's distance from the head, so a larger age means a younger entry.
  always_comb begin
    hit_o   = 1'b0;
    age     = '0;
    bestAge = '0;
    bestIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = PTR_W'(i) - head_i;
      if (valid_i[i] && (tags_i[i] == tag_i) && (!hit_o || (age >= bestAge))) begin
        hit_o   = 1'b1;
        bestAge = age;
        bestIdx = PTR_W'(i);
      end
    end
    onehot_o = hit_o ? ({{(DEPTH-1){1'b0}}, 1'b1} << bestIdx) : '0;
  end

endmodule

// File: rtl/gt_writeback_buffer.sv
// Writeback buffer for evicted dirty lines: circular queue drained to memory, with
// coalescing of repeat evictions and a registered read-forward lookup.
module gt_writeback_buffer
  import gt_cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  gt_writeback_buffer_if.slave bus
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(DEPTH);

  tag_t             tags_q [DEPTH];
  line_t            data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             lookupHit_q, lookupHit_d;
  line_t            lookupData_q, lookupData_d;

  logic             accept, drain, push, coalesce;
  logic             evictHit, lookHit;
  logic [DEPTH-1:0] headOneHot, evictMask, evictOneHot, lookOneHot;
  tag_t             evictTag, lookTag;
  logic             unusedOffsetBits;

  assign evictTag         = addrToTag(bus.evictAddr);
  assign lookTag          = addrToTag(bus.lookupAddr);
  assign unusedOffsetBits = ^{bus.evictAddr[OFFSET_BITS-1:0], bus.lookupAddr[OFFSET_BITS-1:0]};

  assign bus.evictReady = (count_q != FULL_COUNT);
  assign bus.memWrValid = (count_q != '0);
  assign bus.memWrAddr  = {tags_q[head_q], {OFFSET_BITS{1'b0}}};
  assign bus.memWrData  = data_q[head_q];
  assign bus.lookupHit  = lookupHit_q;
  assign bus.lookupData = lookupData_q;
  assign bus.count      = count_q;

  // The head is excluded from coalescing so the line being presented never changes under memory.
  assign headOneHot = {{(DEPTH-1){1'b0}}, 1'b1} << head_q;
  assign evictMask  = valid_q & ~(bus.memWrValid ? headOneHot : '0);

  gt_wb_match #(.DEPTH(DEPTH)) evictMatch (
    .tag_i    (evictTag),
    .tags_i   (tags_q),
    .valid_i  (evictMask),
    .head_i   (head_q),
    .hit_o    (evictHit),
    .onehot_o (evictOneHot)
  );

  gt_wb_match #(.DEPTH(DEPTH)) lookMatch (
    .tag_i    (lookTag),
    .tags_i   (tags_q),
    .valid_i  (valid_q),
    .head_i   (head_q),
    .hit_o    (lookHit),
    .onehot_o (lookOneHot)
  );

  assign accept   = bus.evictValid && bus.evictReady;
  assign drain    = bus.memWrValid && bus.memWrReady;
  assign push     = accept && !evictHit;
  assign coalesce = accept && evictHit;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Lookup results reflect the contents before this edge's accept or drain.
  always_comb begin
    lookupHit_d  = lookHit;
    lookupData_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lookOneHot[i]) lookupData_d = lookupData_d | data_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tags_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      lookupHit_q  <= 1'b0;
      lookupData_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (coalesce && evictOneHot[i]) begin
          data_q[i] <= bus.evictData;
        end else if (push && (tail_q == PTR_W'(i))) begin
          tags_q[i] <= evictTag;
          data_q[i] <= bus.evictData;
        end
      end
      valid_q      <= valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      lookupHit_q  <= lookupHit_d;
      lookupData_q <= lookupData_d;
    end
  end

endmodule

// File: tb/tb_gt_writeback_buffer.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a queue-based model of the writeback buffer.
module tb_gt_writeback_buffer;
  import gt_cache_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    tag_t  tag;
    line_t data;
  } entry_t;

  logic  clk = 1'b0;
  logic  rst;
  int    nChecks = 0;
  int    nFails  = 0;

  entry_t modelQ[$];
  logic   expHit;
  line_t  expData;
  line_t  d1, d2, d3, d4;

  gt_writeback_buffer_if #(.DEPTH(DEPTH)) bus();

  gt_writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic line_t randLine();
    line_t l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom();
    return l;
  endfunction

  // Queue model: index 0 is the line at memory, the back is the youngest.
  task automatic modelStep();
    tag_t lt, et;
    int   n;
    bit   accepted, drained, found;
    lt      = bus.lookupAddr[31:5];
    et      = bus.evictAddr[31:5];
    expHit  = 1'b0;
    expData = '0;
    foreach (modelQ[i]) begin
      if (modelQ[i].tag == lt) begin
        expHit  = 1'b1;
        expData = modelQ[i].data;
      end
    end
    n        = modelQ.size();
    accepted = bus.evictValid && (n < DEPTH);
    drained  = (n > 0) && bus.memWrReady;
    found    = 1'b0;
    if (accepted) begin
      for (int i = 1; i < n; i++) begin
        if (modelQ[i].tag == et) begin
          modelQ[i].data = bus.evictData;
          found = 1'b1;
        end
      end
    end
    if (drained) void'(modelQ.pop_front());
    if (accepted && !found) modelQ.push_back('{tag: et, data: bus.evictData});
  endtask

  task automatic applyStimulus(input logic ev, input logic [31:0] addr, input line_t data,
                               input logic rdy, input logic [31:0] laddr);
    bus.evictValid = ev;
    bus.evictAddr  = addr;
    bus.evictData  = data;
    bus.memWrReady = rdy;
    bus.lookupAddr = laddr;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic clearModel();
    modelQ.delete();
    expHit  = 1'b0;
    expData = '0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("evictReady", 256'(bus.evictReady), 256'(modelQ.size() != DEPTH));
      checkOutput("memWrValid", 256'(bus.memWrValid), 256'(modelQ.size() != 0));
      checkOutput("count", 256'(bus.count), 256'(modelQ.size()));
      if (modelQ.size() > 0) begin
        checkOutput("memWrAddr", 256'(bus.memWrAddr), 256'({modelQ[0].tag, 5'b0}));
        checkOutput("memWrData", bus.memWrData, modelQ[0].data);
      end
      checkOutput("lookupHit", 256'(bus.lookupHit), 256'(expHit));
      checkOutput("lookupData", bus.lookupData, expData);
    end
  end

  initial begin
    d1 = {8{32'h1111_1111}};
    d2 = {8{32'h2222_2222}};
    d3 = {8{32'h3333_3333}};
    d4 = {8{32'h4444_4444}};
    rst = 1'b1;
    bus.evictValid = 1'b0;
    bus.evictAddr  = '0;
    bus.evictData  = '0;
    bus.memWrReady = 1'b0;
    bus.lookupAddr = '0;
    clearModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("resetEvictReady", 256'(bus.evictReady), 256'(1));
    checkOutput("resetMemWrValid", 256'(bus.memWrValid), 256'(0));
    checkOutput("resetCount", 256'(bus.count), 256'(0));
    checkOutput("resetLookupHit", 256'(bus.lookupHit), 256'(0));

    applyStimulus(1'b1, 32'h1000, d1, 1'b0, 32'h1000);
    checkOutput("t1MemWrValid", 256'(bus.memWrValid), 256'(1));
    checkOutput("t1MemWrAddr", 256'(bus.memWrAddr), 256'(32'h1000));
    checkOutput("t1MemWrData", bus.memWrData, d1);
    checkOutput("t1LookupEmpty", 256'(bus.lookupHit), 256'(0));
    applyStimulus(1'b0, 32'h0, '0, 1'b1, 32'h0);
    checkOutput("t1Drained", 256'(bus.count), 256'(0));

    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'((k + 1) << 8), randLine(), 1'b0, 32'h0);
    checkOutput("t2Count", 256'(bus.count), 256'(4));
    checkOutput("t2Full", 256'(bus.evictReady), 256'(0));
    applyStimulus(1'b1, 32'h500, randLine(), 1'b0, 32'h0);
    checkOutput("t2Rejected", 256'(bus.count), 256'(4));
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2DrainOrder", 256'(bus.memWrAddr), 256'((k + 1) << 8));
      applyStimulus(1'b0, 32'h0, '0, 1'b1, 32'h0);
      checkOutput("t2CountDown", 256'(bus.count), 256'(3 - k));
    end

    applyStimulus(1'b1, 32'h2000, d1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h3000, d2, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h3000, d3, 1'b0, 32'h0);
    checkOutput("t3Coalesce", 256'(bus.count), 256'(2));
    checkOutput("t3Head", bus.memWrData, d1);
    applyStimulus(1'b0, 32'h0, '0, 1'b1, 32'h0);
    checkOutput("t3Second", bus.memWrData, d3);
    applyStimulus(1'b0, 32'h0, '0, 1'b1, 32'h0);

    applyStimulus(1'b1, 32'h2000, d1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h2000, d4, 1'b0, 32'h0);
    checkOutput("t4NoHeadCoalesce", 256'(bus.count), 256'(2));
    checkOutput("t4HeadStable", bus.memWrData, d1);
    applyStimulus(1'b0, 32'h0, '0, 1'b0, 32'h2000);
    checkOutput("t4LookupHit", 256'(bus.lookupHit), 256'(1));
    checkOutput("t4LookupYoungest", bus.lookupData, d4);
    applyStimulus(1'b0, 32'h0, '0, 1'b1, 32'h0);
    checkOutput("t4Second", bus.memWrData, d4);
    applyStimulus(1'b0, 32'h0, '0, 1'b1, 32'h0);

    applyStimulus(1'b1, 32'h3000, d3, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, '0, 1'b0, 32'h4000);
    checkOutput("t5MissHit", 256'(bus.lookupHit), 256'(0));
    checkOutput("t5MissData", bus.lookupData, 256'(0));
    applyStimulus(1'b0, 32'h0, '0, 1'b1, 32'h3000);
    checkOutput("t5PreEdgeHit", 256'(bus.lookupHit), 256'(1));
    checkOutput("t5PreEdgeData", bus.lookupData, d3);
    checkOutput("t5Drained", 256'(bus.count), 256'(0));

    applyStimulus(1'b1, 32'h5000, d1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h6000, d2, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h7000, d3, 1'b0, 32'h5000);
    checkOutput("t6Count", 256'(bus.count), 256'(3));
    bus.evictValid = 1'b0;
    bus.memWrReady = 1'b1;
    #2;
    rst = 1'b1;
    clearModel();
    #1;
    checkOutput("t6MemWrValid", 256'(bus.memWrValid), 256'(0));
    checkOutput("t6Count", 256'(bus.count), 256'(0));
    checkOutput("t6MemWrAddr", 256'(bus.memWrAddr), 256'(0));
    checkOutput("t6MemWrData", bus.memWrData, 256'(0));
    checkOutput("t6LookupHit", 256'(bus.lookupHit), 256'(0));
    checkOutput("t6LookupData", bus.lookupData, 256'(0));
    checkOutput("t6EvictReady", 256'(bus.evictReady), 256'(1));
    bus.memWrReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // A small pool of line addresses keeps coalescing, duplicates and full stalls frequent.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 99) < 60),
                    32'(((32'h40 + $urandom_range(0, 5)) << 5) | $urandom_range(0, 31)),
                    randLine(),
                    ($urandom_range(0, 99) < 45),
                    32'(((32'h40 + $urandom_range(0, 6)) << 5) | $urandom_range(0, 31)));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
